// File: rtl/rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rv_wb_arbiter : round-robin writeback arbiter for the register-file write
//                 port, with X0 filtering and a pending-write scoreboard.
// Revision      : 1.0
// ============================================================================
module rv_wb_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [AW-1:0]        a_rd,
  input  logic [DW-1:0]        a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [AW-1:0]        b_rd,
  input  logic [DW-1:0]        b_data,
  output logic                 b_ready,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  output logic                 rf_write,
  output logic [AW-1:0]        rf_writeR,
  output logic [DW-1:0]        rf_write_data,
  output logic [(2**AW)-1:0]   busy
);

  localparam int NREG = 2**AW;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t            pri_q;
  logic            a_req;
  logic            b_req;
  logic            grant_a;
  logic            grant_b;
  logic [NREG-1:0] busy_next;

  // Requests to X0 never compete: they are accepted and dropped on the spot.
  always_comb begin
    a_req   = a_valid && (a_rd != '0);
    b_req   = b_valid && (b_rd != '0);
    grant_a = a_req && (!b_req || (pri_q == PRI_A));
    grant_b = b_req && (!a_req || (pri_q == PRI_B));
    a_ready = a_valid && ((a_rd == '0) || grant_a);
    b_ready = b_valid && ((b_rd == '0) || grant_b);
  end

  // Clear on write completion, flush overrides clear, a new issue overrides both.
  always_comb begin
    busy_next = busy;
    if (rf_write) begin
      busy_next[rf_writeR] = 1'b0;
    end
    if (flush) begin
      busy_next = '0;
    end
    if (iss_valid) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri_q         <= PRI_A;
      rf_write      <= 1'b0;
      rf_writeR     <= '0;
      rf_write_data <= '0;
      busy          <= '0;
    end else begin
      busy <= busy_next;
      if (grant_a) begin
        rf_write      <= 1'b1;
        rf_writeR     <= a_rd;
        rf_write_data <= a_data;
        pri_q         <= PRI_B;
      end else if (grant_b) begin
        rf_write      <= 1'b1;
        rf_writeR     <= b_rd;
        rf_write_data <= b_data;
        pri_q         <= PRI_A;
      end else begin
        rf_write      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rv_wb_arbiter : directed self-checking bench for rv_wb_arbiter.
// Revision         : 1.0
// ============================================================================
module tb_rv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid, flush;
  logic [4:0]  a_rd, b_rd, iss_rd;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, rf_write;
  logic [4:0]  rf_writeR;
  logic [63:0] rf_write_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  rv_wb_arbiter #(.DW(64), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .rf_write(rf_write), .rf_writeR(rf_writeR), .rf_write_data(rf_write_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who is favoured next, what the write port shows, and
  // which registers still await their value.
  int          m_pri;
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [31:0] m_busy;

  function automatic int winner();
    bit ar = a_valid && (a_rd != 0);
    bit br = b_valid && (b_rd != 0);
    if (ar && br) return m_pri;
    if (ar) return 0;
    if (br) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] next_busy();
    logic [31:0] nb;
    nb = '0;
    for (int n = 1; n < 32; n++) begin
      nb[n] = m_busy[n];
      if (m_wr && int'(m_rd) == n) nb[n] = 1'b0;
      if (flush) nb[n] = 1'b0;
      if (iss_valid && int'(iss_rd) == n) nb[n] = 1'b1;
    end
    return nb;
  endfunction

  function automatic logic exp_a_ready();
    return a_valid && ((a_rd == 0) || (winner() == 0));
  endfunction

  function automatic logic exp_b_ready();
    return b_valid && ((b_rd == 0) || (winner() == 1));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pri  <= 0;
      m_wr   <= 1'b0;
      m_rd   <= '0;
      m_data <= '0;
      m_busy <= '0;
    end else begin
      m_busy <= next_busy();
      case (winner())
        0: begin m_wr <= 1'b1; m_rd <= a_rd; m_data <= a_data; m_pri <= 1; end
        1: begin m_wr <= 1'b1; m_rd <= b_rd; m_data <= b_data; m_pri <= 0; end
        default: m_wr <= 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("a_ready", a_ready, exp_a_ready());
    chk("b_ready", b_ready, exp_b_ready());
    chk("rf_write", rf_write, m_wr);
    chk("rf_writeR", rf_writeR, m_rd);
    chk("rf_write_data", rf_write_data, m_data);
    chk("busy", busy, m_busy);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sb_list[4] = '{4, 5, 9, 12};

  initial begin
    rst = 1'b0; flush = 1'b0;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hA5A5_0000_0000_0005;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0;

    // Reset held, then release with A waiting
    tick(); tick();
    chk("rst_rf_write", rf_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rf_writeR", rf_writeR, 0);
    rst = 1'b1;
    tick();
    chk("rel_rf_write", rf_write, 1);
    chk("rel_rf_writeR", rf_writeR, 5);
    chk("rel_data", rf_write_data, 64'hA5A5_0000_0000_0005);
    a_valid = 1'b0;

    // Contention from a fresh reset: A,B,A,B
    rst = 1'b0; #2; rst = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h3333;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h7777;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("single_ready", a_ready & b_ready, 0);
      tick();
      chk("cont_rf_write", rf_write, 1);
      chk("cont_rf_writeR", rf_writeR, (i % 2 == 0) ? 64'd3 : 64'd7);
    end

    // X0 request from A alongside a real request from B
    a_rd = 5'd0; a_data = 64'hFFFF; b_rd = 5'd9; b_data = 64'h9999;
    #1;
    chk("x0_a_ready", a_ready, 1);
    chk("x0_b_ready", b_ready, 1);
    tick();
    chk("x0_rf_writeR", rf_writeR, 9);
    chk("x0_data", rf_write_data, 64'h9999);
    a_rd = 5'd3; b_rd = 5'd7;
    #1;
    chk("x0_ptr_a", a_ready, 1);
    chk("x0_ptr_b", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;

    // Scoreboard lifetime of X12
    tick();
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    chk("sb_set", busy[12], 1);
    iss_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd12; b_data = 64'hC0DE;
    tick();
    chk("sb_wr_cycle", rf_write && (rf_writeR == 5'd12), 1);
    chk("sb_hold", busy[12], 1);
    b_valid = 1'b0;
    tick();
    chk("sb_clear", busy[12], 0);

    // Set and clear of X4 on the same edge
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd4; b_data = 64'h4;
    tick();
    chk("col_busy_before", busy[4], 1);
    b_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    chk("col_set_wins", busy[4], 1);
    iss_rd = 5'd0;
    tick();
    chk("x0_busy0", busy[0], 0);
    chk("col_keep", busy[4], 1);
    iss_valid = 1'b0;

    // Flush with a grant in flight and a same-cycle issue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clear", busy, 0);
    iss_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iss_rd = 5'(sb_list[i]);
      tick();
    end
    iss_valid = 1'b0;
    chk("busy_pattern", busy, 32'h0000_1230);
    a_valid = 1'b1; a_rd = 5'd6; a_data = 64'h6666;
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd20;
    tick();
    chk("flush_busy", busy, 32'h0010_0000);
    chk("flush_rf_write", rf_write, 1);
    chk("flush_rf_writeR", rf_writeR, 6);
    a_valid = 1'b0; flush = 1'b0; iss_valid = 1'b0;

    // Asynchronous reset in the middle of the write cycle
    rst = 1'b0;
    #1;
    chk("rst_kill_write", rf_write, 0);
    chk("rst_kill_busy", busy, 0);
    #1;
    rst = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rv_wb_arbiter.md
Name: rv_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: A (ALU/branch-link path) and B (load / multi-cycle unit).
- Uses valid/ready handshakes, round-robin arbitration and a registered write-port drive.
- Maintains a 32-bit pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the 64-bit, 32-entry register file. X0 writes are filtered here.

Parameters:
DW  64  data width of writeback values and write port
AW  5   register index width; scoreboard depth is 2**AW

Ports:
clk         input   1    clock, rising edge
rst         input   1    reset, asynchronous, active-low
a_valid     input   1    source A has a writeback
a_rd        input   AW   source A destination register
a_data      input   DW   source A result
a_ready     output  1    source A accepted this cycle
b_valid     input   1    source B has a writeback
b_rd        input   AW   source B destination register
b_data      input   DW   source B result
b_ready     output  1    source B accepted this cycle
iss_valid   input   1    an instruction issued that will write iss_rd
iss_rd      input   AW   destination reserved at issue
flush       input   1    pipeline flush; clears scoreboard
rf_write    output  1    register-file write enable
rf_writeR   output  AW   register-file write index
rf_write_data output DW  register-file write data
busy        output  2**AW  scoreboard: bit n = write to Xn pending

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-low.
- Reset (rst low, asynchronous):
  - rf_write=0, rf_writeR=0, rf_write_data=0.
  - busy=0.
  - Round-robin pointer selects A.
  - An in-flight rf_write pulse is killed immediately.
- Handshake:
  - Transfer occurs when valid && ready in the same cycle.
  - a_ready and b_ready are combinational from the valids, the rd fields and the pointer.
  - Sources hold valid/rd/data stable until ready.
- X0 filtering:
  - A request with rd==0 is always ready, is discarded, generates no rf_write, and does not move the pointer.
  - This holds even when the other source is also granted in the same cycle.
- Arbitration (requests with rd!=0):
  - Only one valid: it is granted.
  - Both valid: the source named by the pointer is granted; the other sees ready=0.
  - After any nonzero grant, the pointer moves to the non-granted source.
  - This guarantees no source waits more than one cycle under contention.
- Write-port timing:
  - A grant at edge N drives rf_write=1 with rf_writeR/rf_write_data during cycle N+1: a one-cycle registered pulse, one write per cycle max.
  - With no grant, rf_write=0 and rf_writeR/rf_write_data hold their last values.
  - Back-to-back grants give continuous rf_write=1.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets busy[iss_rd] at the next edge.
  - busy[n] clears at the edge that ends the rf_write cycle for index n, so busy falls exactly when the register file holds the value.
  - Set and clear of the same index at the same edge: set wins, because the new producer is outstanding.
  - busy[0] is constant 0; iss_rd==0 is ignored.
  - flush clears all busy bits at the next edge, and has priority over clear.
  - iss_valid in the same cycle as flush still sets its bit (the issuing instruction is post-flush).
  - flush does not cancel accepted writebacks or the pending rf_write.
- A writeback to a register that is not busy is still written; the scoreboard bit stays 0.

Test Plan:
- Reset: hold rst low with a_valid=1, a_rd=5 → rf_write=0, busy=0, a_ready irrelevant. Release rst → A granted, and the next cycle rf_write=1, rf_writeR=5, rf_write_data=a_data.
- Contention: a_valid=b_valid=1 for 4 cycles (a_rd=3, b_rd=7) from reset → grant order A,B,A,B. rf_writeR sequence 3,7,3,7 with rf_write high 4 consecutive cycles. Ready is never high on both.
- X0 filtering: a_valid=1, a_rd=0, a_data=64'hFFFF; b_valid=1, b_rd=9 → a_ready=1 and b_ready=1 the same cycle. Next cycle rf_writeR=9 only, and the pointer is unchanged.
- Scoreboard life: iss_valid, iss_rd=12 → busy[12]=1 next cycle. b writes rd=12 → busy[12] stays 1 during the rf_write cycle and is 0 the cycle after.
- Set/clear collision: busy[4]=1 and rf_write to X4 in progress while iss_valid, iss_rd=4 → busy[4] remains 1. iss_rd=0 → busy[0] stays 0.
- Flush/reset mid-op: with busy=0x0000_1230 and a grant pending, flush=1 → busy=0 next edge while the rf_write still occurs. Asserting rst during an rf_write cycle → rf_write drops to 0 immediately.
